spi_chunk_engine: RTL and testbench
===================================

Name: spi_chunk_engine

Overview:
- Bit-level SPI front end that sits directly upstream of the MITM decision logic.
- Watches the pre-synchronised SPI lines (mode 0) and captures MOSI/MISO bits into chunks whose length is set by the logic (`data_size`).
- Pulses `eval` at transaction start and at every chunk boundary.
- Drives the outgoing MOSI/MISO lines, passing the real bits through or substituting the logic's fake data MSB-first.

Parameters:
MAX_DATA_SIZE, 9, widest chunk in bits; width of all data buses.
DATA_SIZE_WIDTH, $clog2(MAX_DATA_SIZE+1), width of data_size and bit counter.

Ports:
sys_clk  in  1  system clock; must be ≥8× SCLK frequency.
rst  in  1  synchronous, active-high reset.
cs_n_in  in  1  chip select from master, already synchronised, active low.
sclk_in  in  1  SPI clock from master, already synchronised.
mosi_in  in  1  real MOSI from master, already synchronised.
miso_in  in  1  real MISO from slave, already synchronised.
mosi_out  out  1  MOSI toward slave.
miso_out  out  1  MISO toward master.
mitm_start  out  1  one-cycle pulse at transaction start.
eval  out  1  one-cycle pulse: chunk complete / request next chunk config.
real_mosi_data  out  MAX_DATA_SIZE  captured MOSI chunk.
real_miso_data  out  MAX_DATA_SIZE  captured MISO chunk.
data_size  in  DATA_SIZE_WIDTH  next chunk length; 0 = pass-through until CS release.
fake_mosi_data  in  MAX_DATA_SIZE  fake MOSI bits, first bit at [MAX_DATA_SIZE-1].
fake_miso_data  in  MAX_DATA_SIZE  fake MISO bits, first bit at [MAX_DATA_SIZE-1].
fake_mosi_select  in  1  substitute MOSI for next chunk.
fake_miso_select  in  1  substitute MISO for next chunk.
eval_done  in  1  logic ready flag; engine loads config only when high.
mitm_done  in  1  logic finished the current transaction.
busy  out  1  high outside IDLE.
overrun  out  1  sticky: SCLK edge arrived while no chunk was active.

Behaviour:
- Reset values:
  - outputs: mitm_start=0, eval=0, real_*_data=0, busy=0, overrun=0.
  - internal: state=IDLE, counter=0, latched selects=0, fake shift regs=0, sclk_prev=1, cs_prev=1.
- Edge detection: rise = sclk_in & ~sclk_prev; fall = ~sclk_in & sclk_prev; CS assert = ~cs_n_in & cs_prev.
- Output mux (combinational):
  - miso_out = (~cs_n_in & sel_miso_l) ? miso_sr[MAX_DATA_SIZE-1] : miso_in.
  - mosi_out: same rule with sel_mosi_l / mosi_sr / mosi_in.
- IDLE:
  - CS assert with mitm_done=1 → pulse mitm_start next cycle, enter START.
  - CS assert with mitm_done=0 → stay in IDLE, pass through.
- START: pulse eval one cycle after mitm_start; enter SETTLE.
- SETTLE:
  - Waits 2 cycles after the eval pulse, then waits for eval_done=1.
  - On leaving, latches data_size, both selects and both fake data words into the shift regs; clears counter and real_*_data.
  - data_size=0 → PASS; otherwise → CHUNK.
- CHUNK:
  - rise: real_x_data <= {real_x_data[MAX-2:0], x_in}, so the first bit ends at [data_size-1]; counter+1.
  - fall: fake shift regs shift left by one.
  - When counter == latched data_size after a rise: pulse eval next cycle, enter SETTLE; real_*_data then holds stable until the next chunk load.
- PASS: selects cleared, no evals; waits for CS release.
- CS release (cs_n_in=1) in any non-IDLE state:
  - Aborts the partial chunk; selects cleared immediately.
  - mitm_done=1 → IDLE.
  - mitm_done=0 → FLUSH.
- FLUSH: pulse eval, wait 2 cycles, repeat until mitm_done=1 (max 8 pulses), then IDLE.
- overrun: set on rise in START/SETTLE; the bit is dropped.
- Simultaneous CS release and rise: CS release wins, the bit is discarded.
- rst mid-transaction: immediate return to reset values; outputs revert to pass-through in the same cycle the state clears.

Optional Feature:
- Macro ABORT_CNT_EN.
  - Defined: adds output abort_cnt[7:0], reset 0, incremented on each CS release from CHUNK with counter ≠ 0; saturates at 255.
  - Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, CS high, toggle SCLK → miso_out/mosi_out follow inputs, no eval, overrun=0, busy=0.
- CS assert → mitm_start at T+1, eval at T+2; logic returns data_size=3 → three rises with MOSI 1,1,0 → eval pulse, real_mosi_data[2:0]=3'b110.
- Continue with data_size=9 (address), then data_size=8, fake_miso_select=1, fake_miso_data=9'h048 → miso_out shows 0,0,1,0,0,1,0,0 (0x24) across 8 rises, real MISO ignored.
- Instruction 3'b101 → logic returns data_size=0, mitm_done=1 → PASS, no further eval; CS release → IDLE.
- CS release after 4 of 9 bits with mitm_done=0 → FLUSH pulses eval until mitm_done=1; abort_cnt=1 when ABORT_CNT_EN is defined.
- Rise injected 1 cycle after an eval pulse → overrun=1, sticky until rst; rst asserted mid-CHUNK → all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_chunk_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_chunk_engine
// Description : Bit-level SPI (mode 0) front end for the MITM decision logic.
//               Captures MOSI/MISO into chunks whose length is set by the
//               logic, pulses eval at transaction start and at each chunk
//               boundary, and drives outgoing MOSI/MISO either as pass-through
//               or with fake data substituted MSB-first.
//
// Ports:
//   sys_clk, rst          : system clock (>= 8x SCLK), synchronous active-high reset
//   cs_n_in, sclk_in,
//   mosi_in, miso_in      : pre-synchronised SPI lines
//   mosi_out, miso_out    : SPI lines toward slave / master
//   mitm_start, eval      : one-cycle pulses toward the decision logic
//   real_mosi_data,
//   real_miso_data        : captured chunk, first bit at [data_size-1]
//   data_size, fake_*,
//   fake_*_select         : next chunk configuration (0 size = pass-through)
//   eval_done, mitm_done  : handshake from the decision logic
//   busy, overrun         : status (overrun is sticky until reset)
//   abort_cnt             : only with ABORT_CNT_EN defined; saturating count
//                           of CS releases in the middle of a chunk
//
// Optional feature macro: ABORT_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module spi_chunk_engine #(
  parameter int MAX_DATA_SIZE   = 9,
  parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       cs_n_in,
  input  logic                       sclk_in,
  input  logic                       mosi_in,
  input  logic                       miso_in,
  output logic                       mosi_out,
  output logic                       miso_out,
  output logic                       mitm_start,
  output logic                       eval,
  output logic [MAX_DATA_SIZE-1:0]   real_mosi_data,
  output logic [MAX_DATA_SIZE-1:0]   real_miso_data,
  input  logic [DATA_SIZE_WIDTH-1:0] data_size,
  input  logic [MAX_DATA_SIZE-1:0]   fake_mosi_data,
  input  logic [MAX_DATA_SIZE-1:0]   fake_miso_data,
  input  logic                       fake_mosi_select,
  input  logic                       fake_miso_select,
  input  logic                       eval_done,
  input  logic                       mitm_done,
  output logic                       busy,
  output logic                       overrun
`ifdef ABORT_CNT_EN
  ,
  output logic [7:0]                 abort_cnt
`endif
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_CHUNK  = 3'd3;
  localparam logic [2:0] c_PASS   = 3'd4;
  localparam logic [2:0] c_FLUSH  = 3'd5;

  localparam logic [1:0] c_SETTLE_WAIT = 2'd2;
  localparam logic [3:0] c_FLUSH_MAX   = 4'd8;

  logic [2:0]                 state_q,     state_d;
  logic [DATA_SIZE_WIDTH-1:0] cnt_q,       cnt_d;
  logic [DATA_SIZE_WIDTH-1:0] size_q,      size_d;
  logic                       sel_mosi_q,  sel_mosi_d;
  logic                       sel_miso_q,  sel_miso_d;
  logic [MAX_DATA_SIZE-1:0]   mosi_sr_q,   mosi_sr_d;
  logic [MAX_DATA_SIZE-1:0]   miso_sr_q,   miso_sr_d;
  logic [MAX_DATA_SIZE-1:0]   real_mosi_q, real_mosi_d;
  logic [MAX_DATA_SIZE-1:0]   real_miso_q, real_miso_d;
  logic                       sclk_prev_q, sclk_prev_d;
  logic                       cs_prev_q,   cs_prev_d;
  logic                       start_q,     start_d;
  logic                       eval_q,      eval_d;
  logic                       overrun_q,   overrun_d;
  logic [1:0]                 wait_q,      wait_d;
  logic [3:0]                 flush_q,     flush_d;
`ifdef ABORT_CNT_EN
  logic [7:0]                 abort_q,     abort_d;
`endif

  logic                       w_rise;
  logic                       w_fall;
  logic                       w_cs_assert;
  logic [DATA_SIZE_WIDTH-1:0] w_cnt_inc;

  assign w_rise      = sclk_in & ~sclk_prev_q;
  assign w_fall      = ~sclk_in & sclk_prev_q;
  assign w_cs_assert = ~cs_n_in & cs_prev_q;
  assign w_cnt_inc   = cnt_q + 1'b1;

  // Selects are registered, so a reset or CS release returns the lines to
  // pass-through without any combinational dependence on the state.
  assign mosi_out = (~cs_n_in & sel_mosi_q) ? mosi_sr_q[MAX_DATA_SIZE-1] : mosi_in;
  assign miso_out = (~cs_n_in & sel_miso_q) ? miso_sr_q[MAX_DATA_SIZE-1] : miso_in;

  assign mitm_start     = start_q;
  assign eval           = eval_q;
  assign real_mosi_data = real_mosi_q;
  assign real_miso_data = real_miso_q;
  assign busy           = (state_q != c_IDLE);
  assign overrun        = overrun_q;
`ifdef ABORT_CNT_EN
  assign abort_cnt      = abort_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    sel_mosi_d  = sel_mosi_q;
    sel_miso_d  = sel_miso_q;
    mosi_sr_d   = mosi_sr_q;
    miso_sr_d   = miso_sr_q;
    real_mosi_d = real_mosi_q;
    real_miso_d = real_miso_q;
    sclk_prev_d = sclk_in;
    cs_prev_d   = cs_n_in;
    start_d     = 1'b0;
    eval_d      = 1'b0;
    overrun_d   = overrun_q;
    wait_d      = wait_q;
    flush_d     = flush_q;
`ifdef ABORT_CNT_EN
    abort_d     = abort_q;
`endif

    // CS release takes priority over any SCLK edge in the same cycle.
    // FLUSH is excluded because CS is already high while it runs.
    if (cs_n_in && (state_q != c_IDLE) && (state_q != c_FLUSH)) begin
      sel_mosi_d = 1'b0;
      sel_miso_d = 1'b0;
      wait_d     = 2'd0;
      flush_d    = 4'd0;
      state_d    = mitm_done ? c_IDLE : c_FLUSH;
`ifdef ABORT_CNT_EN
      if ((state_q == c_CHUNK) && (cnt_q != '0) && (abort_q != 8'hFF)) begin
        abort_d = abort_q + 8'd1;
      end
`endif
    end else begin
      case (state_q)
        c_IDLE: begin
          if (w_cs_assert && mitm_done) begin
            start_d = 1'b1;
            state_d = c_START;
          end
        end

        c_START: begin
          if (w_rise) begin
            overrun_d = 1'b1;
          end
          eval_d  = 1'b1;
          wait_d  = c_SETTLE_WAIT;
          state_d = c_SETTLE;
        end

        c_SETTLE: begin
          if (w_rise) begin
            overrun_d = 1'b1;
          end
          if (wait_q != 2'd0) begin
            wait_d = wait_q - 2'd1;
          end else if (eval_done) begin
            size_d      = data_size;
            cnt_d       = '0;
            real_mosi_d = '0;
            real_miso_d = '0;
            mosi_sr_d   = fake_mosi_data;
            miso_sr_d   = fake_miso_data;
            if (data_size == '0) begin
              sel_mosi_d = 1'b0;
              sel_miso_d = 1'b0;
              state_d    = c_PASS;
            end else begin
              sel_mosi_d = fake_mosi_select;
              sel_miso_d = fake_miso_select;
              state_d    = c_CHUNK;
            end
          end
        end

        c_CHUNK: begin
          if (w_rise) begin
            real_mosi_d = {real_mosi_q[MAX_DATA_SIZE-2:0], mosi_in};
            real_miso_d = {real_miso_q[MAX_DATA_SIZE-2:0], miso_in};
            cnt_d       = w_cnt_inc;
            if (w_cnt_inc == size_q) begin
              eval_d  = 1'b1;
              wait_d  = c_SETTLE_WAIT;
              state_d = c_SETTLE;
            end
          end else if (w_fall && (cnt_q != '0)) begin
            // A fall seen before the first rise of a chunk is the trailing
            // fall of the previous chunk; shifting on it would skip the
            // first fake bit that was just loaded.
            mosi_sr_d = {mosi_sr_q[MAX_DATA_SIZE-2:0], 1'b0};
            miso_sr_d = {miso_sr_q[MAX_DATA_SIZE-2:0], 1'b0};
          end
        end

        c_PASS: begin
          sel_mosi_d = 1'b0;
          sel_miso_d = 1'b0;
        end

        c_FLUSH: begin
          if (mitm_done) begin
            state_d = c_IDLE;
          end else if (wait_q != 2'd0) begin
            wait_d = wait_q - 2'd1;
          end else if (flush_q == c_FLUSH_MAX) begin
            state_d = c_IDLE;
          end else begin
            eval_d  = 1'b1;
            flush_d = flush_q + 4'd1;
            wait_d  = c_SETTLE_WAIT;
          end
        end

        default: begin
          state_d = c_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      sel_mosi_q  <= 1'b0;
      sel_miso_q  <= 1'b0;
      mosi_sr_q   <= '0;
      miso_sr_q   <= '0;
      real_mosi_q <= '0;
      real_miso_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      start_q     <= 1'b0;
      eval_q      <= 1'b0;
      overrun_q   <= 1'b0;
      wait_q      <= 2'd0;
      flush_q     <= 4'd0;
`ifdef ABORT_CNT_EN
      abort_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      sel_mosi_q  <= sel_mosi_d;
      sel_miso_q  <= sel_miso_d;
      mosi_sr_q   <= mosi_sr_d;
      miso_sr_q   <= miso_sr_d;
      real_mosi_q <= real_mosi_d;
      real_miso_q <= real_miso_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      start_q     <= start_d;
      eval_q      <= eval_d;
      overrun_q   <= overrun_d;
      wait_q      <= wait_d;
      flush_q     <= flush_d;
`ifdef ABORT_CNT_EN
      abort_q     <= abort_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_chunk_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_chunk_engine
// Description : Self-checking bench for spi_chunk_engine. Random SPI
//               transactions are generated from a chunk list; expected
//               eval/start/line values are queued when stimulus is issued and
//               a monitor compares them when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_chunk_engine;

  localparam int MAX  = 9;
  localparam int DSW  = 4;
  localparam int HALF = 8;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic           cs_n_in = 1'b1;
  logic           sclk_in = 1'b0;
  logic           mosi_in = 1'b0;
  logic           miso_in = 1'b0;
  logic           mosi_out, miso_out, mitm_start, eval, busy, overrun;
  logic [MAX-1:0] real_mosi_data, real_miso_data;
  logic [DSW-1:0] data_size = '0;
  logic [MAX-1:0] fake_mosi_data = '0;
  logic [MAX-1:0] fake_miso_data = '0;
  logic           fake_mosi_select = 1'b0;
  logic           fake_miso_select = 1'b0;
  logic           eval_done = 1'b1;
  logic           mitm_done = 1'b1;
`ifdef ABORT_CNT_EN
  logic [7:0]     abort_cnt;
`endif

  spi_chunk_engine #(.MAX_DATA_SIZE(MAX), .DATA_SIZE_WIDTH(DSW)) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .cs_n_in          (cs_n_in),
    .sclk_in          (sclk_in),
    .mosi_in          (mosi_in),
    .miso_in          (miso_in),
    .mosi_out         (mosi_out),
    .miso_out         (miso_out),
    .mitm_start       (mitm_start),
    .eval             (eval),
    .real_mosi_data   (real_mosi_data),
    .real_miso_data   (real_miso_data),
    .data_size        (data_size),
    .fake_mosi_data   (fake_mosi_data),
    .fake_miso_data   (fake_miso_data),
    .fake_mosi_select (fake_mosi_select),
    .fake_miso_select (fake_miso_select),
    .eval_done        (eval_done),
    .mitm_done        (mitm_done),
    .busy             (busy),
    .overrun          (overrun)
`ifdef ABORT_CNT_EN
    ,
    .abort_cnt        (abort_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0]     size;
    logic           smo;
    logic           smi;
    logic [MAX-1:0] fmo;
    logic [MAX-1:0] fmi;
  } cfg_t;

  // kind: 0 = transaction start, 1 = completed chunk, 2 = flush
  typedef struct packed {
    logic [1:0]     kind;
    logic [MAX-1:0] mo;
    logic [MAX-1:0] mi;
  } ev_t;

  ev_t        ev_q[$];
  logic [1:0] rise_q[$];
  int         pend_starts;
  int         model_abort;
  int         checks;
  int         errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       mon_sclk_prev  = 1'b0;
  logic       mon_start_prev = 1'b0;
  ev_t        mon_ev;
  logic [1:0] mon_re;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (sclk_in && !mon_sclk_prev) begin
        chk("rise_expected", rise_q.size() > 0, 1);
        if (rise_q.size() > 0) begin
          mon_re = rise_q.pop_front();
          chk("mosi_out", mosi_out, mon_re[1]);
          chk("miso_out", miso_out, mon_re[0]);
        end
      end
      if (mitm_start) begin
        chk("start_expected", pend_starts > 0, 1);
        if (pend_starts > 0) pend_starts--;
      end
      if (eval) begin
        chk("eval_expected", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          mon_ev = ev_q.pop_front();
          case (mon_ev.kind)
            2'd0: chk("eval_after_start", mon_start_prev, 1);
            2'd1: begin
              chk("real_mosi_data", real_mosi_data, mon_ev.mo);
              chk("real_miso_data", real_miso_data, mon_ev.mi);
              chk("eval_after_rise", sclk_in, 1);
            end
            default: chk("flush_busy", busy, 1);
          endcase
        end
      end
    end
    mon_sclk_prev  = sclk_in;
    mon_start_prev = mitm_start;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [MAX-1:0] mo, input logic [MAX-1:0] mi);
    ev_t e;
    e.kind = k;
    e.mo   = mo;
    e.mi   = mi;
    ev_q.push_back(e);
  endtask

  task automatic apply_cfg(input cfg_t c);
    data_size        = c.size;
    fake_mosi_select = c.smo;
    fake_miso_select = c.smi;
    fake_mosi_data   = c.fmo;
    fake_miso_data   = c.fmi;
  endtask

  function automatic cfg_t rand_cfg(input int lo);
    cfg_t c;
    c.size = 4'($urandom_range(MAX, lo));
    c.smo  = 1'($urandom_range(1, 0));
    c.smi  = 1'($urandom_range(1, 0));
    c.fmo  = 9'($urandom_range(511, 0));
    c.fmi  = 9'($urandom_range(511, 0));
    return c;
  endfunction

  // One SCLK period with no substitution expected.
  task automatic pass_bit();
    logic mo, mi;
    mo = 1'($urandom_range(1, 0));
    mi = 1'($urandom_range(1, 0));
    mosi_in = mo;
    miso_in = mi;
    tick(HALF);
    rise_q.push_back({mo, mi});
    sclk_in = 1'b1;
    tick(HALF);
    sclk_in = 1'b0;
  endtask

  task automatic check_idle_state();
    chk("idle_after_txn", busy, 0);
    chk("eval_queue_drained", ev_q.size(), 0);
    chk("rise_queue_drained", rise_q.size(), 0);
    chk("starts_drained", pend_starts, 0);
    chk("overrun_clear", overrun, 0);
`ifdef ABORT_CNT_EN
    chk("abort_cnt", abort_cnt, model_abort);
`endif
  endtask

  // ending: 0 = PASS then normal release, 1 = mid-chunk abort with flush,
  //         2 = mid-chunk abort with mitm_done already high
  task automatic run_txn();
    cfg_t           ch[4];
    cfg_t           zero_cfg;
    int             ending, nch, nbits, sz;
    logic [MAX-1:0] wmo, wmi;
    logic           mo, mi, emo, emi;
    ending = $urandom_range(2, 0);
    nch    = (ending == 0) ? $urandom_range(4, 0) : $urandom_range(4, 1);
    for (int i = 0; i < 4; i++) ch[i] = rand_cfg((ending != 0 && i == nch - 1) ? 2 : 1);
    zero_cfg = '0;
    apply_cfg(nch > 0 ? ch[0] : zero_cfg);
    mitm_done = 1'b1;
    eval_done = 1'b1;
    pend_starts++;
    push_ev(2'd0, '0, '0);
    cs_n_in = 1'b0;
    tick(2);
    for (int c = 0; c < nch; c++) begin
      sz    = int'(ch[c].size);
      nbits = (ending != 0 && c == nch - 1) ? $urandom_range(sz - 1, 1) : sz;
      wmo   = '0;
      wmi   = '0;
      for (int b = 0; b < nbits; b++) begin
        mo  = 1'($urandom_range(1, 0));
        mi  = 1'($urandom_range(1, 0));
        mosi_in = mo;
        miso_in = mi;
        // Captured word is the bit sequence read as a binary number, MSB first.
        wmo = wmo * 9'd2 + {8'd0, mo};
        wmi = wmi * 9'd2 + {8'd0, mi};
        emo = ch[c].smo ? ch[c].fmo[MAX-1-b] : mo;
        emi = ch[c].smi ? ch[c].fmi[MAX-1-b] : mi;
        tick(HALF);
        rise_q.push_back({emo, emi});
        if (b == nbits - 1 && nbits == sz) push_ev(2'd1, wmo, wmi);
        sclk_in = 1'b1;
        if (b == 0) apply_cfg(c + 1 < nch ? ch[c + 1] : zero_cfg);
        tick(HALF);
        sclk_in = 1'b0;
      end
    end
    if (ending == 0) begin
      repeat ($urandom_range(3, 0)) pass_bit();
      tick(HALF);
      cs_n_in = 1'b1;
    end else begin
      tick(HALF);
      model_abort = (model_abort < 255) ? model_abort + 1 : 255;
      if (ending == 1) begin
        mitm_done = 1'b0;
        repeat (8) push_ev(2'd2, '0, '0);
      end
      cs_n_in = 1'b1;
    end
    for (int k = 0; k < 80 && busy; k++) tick(1);
    mitm_done = 1'b1;
    tick(2);
    check_idle_state();
    tick($urandom_range(6, 2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cfg_t c;
    checks      = 0;
    errors      = 0;
    pend_starts = 0;
    model_abort = 0;

    rst     = 1'b1;
    miso_in = 1'b1;
    mosi_in = 1'b0;
    tick(3);
    chk("rst_mitm_start", mitm_start, 0);
    chk("rst_eval", eval, 0);
    chk("rst_real_mosi", real_mosi_data, 0);
    chk("rst_real_miso", real_miso_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_miso_pass", miso_out, 1);
    chk("rst_mosi_pass", mosi_out, 0);
`ifdef ABORT_CNT_EN
    chk("rst_abort_cnt", abort_cnt, 0);
`endif
    rst = 1'b0;
    tick(2);

    // CS high: lines pass straight through, nothing else happens.
    repeat (4) pass_bit();
    tick(2);
    check_idle_state();

    repeat (40) run_txn();

    // Rise one cycle after the start eval while the logic holds eval_done low.
    c      = '0;
    c.size = 4'd4;
    apply_cfg(c);
    eval_done = 1'b0;
    mitm_done = 1'b1;
    pend_starts++;
    push_ev(2'd0, '0, '0);
    cs_n_in = 1'b0;
    tick(3);
    mosi_in = 1'b1;
    miso_in = 1'b0;
    rise_q.push_back(2'b10);
    sclk_in = 1'b1;
    tick(2);
    chk("overrun_set", overrun, 1);
    tick(6);
    sclk_in   = 1'b0;
    eval_done = 1'b1;
    tick(4);
    chk("overrun_sticky", overrun, 1);
    chk("busy_in_chunk", busy, 1);
    pass_bit();
    pass_bit();

    // Reset in the middle of the chunk.
    mitm_done = 1'b0;
    mosi_in   = 1'b0;
    miso_in   = 1'b1;
    rst       = 1'b1;
    tick(1);
    model_abort = 0;
    chk("midrst_mitm_start", mitm_start, 0);
    chk("midrst_eval", eval, 0);
    chk("midrst_real_mosi", real_mosi_data, 0);
    chk("midrst_real_miso", real_miso_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_mosi_pass", mosi_out, 0);
    chk("midrst_miso_pass", miso_out, 1);
    rst     = 1'b0;
    cs_n_in = 1'b1;
    tick(3);
    mitm_done = 1'b1;
    check_idle_state();

    repeat (4) run_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
